serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 119 +++++++++++
 tb/tb_serial_adder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_adder_pkg;

  // Default operand/sum width in bits.
  localparam int unsigned SA_WIDTH_DEFAULT = 8;

  // FSM state type, kept as plain encoded constants for legacy compatibility.
  typedef logic [1:0] sa_state_t;

  localparam sa_state_t ST_IDLE = 2'd0;
  localparam sa_state_t ST_RUN  = 2'd1;
  localparam sa_state_t ST_DONE = 2'd2;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// One-bit combinational full adder used as the serial bit slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands are captured on an accepted start,
// then one bit per clock is summed LSB-first through a single full adder.
// The result and carry-out are published together on the last bit and
// held until the next completion.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned     CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  sa_state_t        state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  // Holds the sum bits produced so far; the bit of the current edge is
  // appended on top, so only WIDTH-1 bits need storing.
  logic [WIDTH-2:0] res_sh_r;
  logic             carry_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;

  logic             fa_sum_s;
  logic             fa_cout_s;
  logic [WIDTH-1:0] res_next_s;

  full_adder u_slice (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  // Result register contents after this edge's sum bit enters at the MSB.
  always_comb begin
    res_next_s = {fa_sum_s, res_sh_r};
  end

  // FSM, operand/result shifting, bit counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CW{1'b0}};
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      res_sh_r <= {(WIDTH-1){1'b0}};
      carry_r  <= 1'b0;
      sum_r    <= {WIDTH{1'b0}};
      cout_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (start) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            carry_r  <= cin;
            res_sh_r <= {(WIDTH-1){1'b0}};
            cnt_r    <= {CW{1'b0}};
            state_r  <= ST_RUN;
            busy_r   <= 1'b1;
          end else begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
          end
        end
        ST_RUN: begin
          // start is deliberately not looked at here.
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          res_sh_r <= res_next_s[WIDTH-1:1];
          carry_r  <= fa_cout_s;
          cnt_r    <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            sum_r   <= res_next_s;
            cout_r  <= fa_cout_s;
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder at WIDTH=8 plus an
// exhaustive sweep of a WIDTH=4 instance.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start4;
  logic [3:0] a4, b4;
  logic       cin4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int n_vec;
  int n_bad;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One WIDTH=8 operation: start at edge 0, scramble operands afterwards,
  // check latency, busy duration, result and the single-cycle done pulse.
  task automatic do_op8(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        input logic [7:0] es, input logic ec, input string nm);
    int lat;
    int bcnt;
    @(negedge clk);
    a8 = va; b8 = vb; cin8 = vc; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = ~va; b8 = va ^ vb; cin8 = ~vc;
    bcnt = busy8 ? 1 : 0;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy8) bcnt++;
    end
    chk({nm, " latency"}, lat, 8);
    chk({nm, " busy_cycles"}, bcnt, 8);
    chk({nm, " sum"}, {24'd0, sum8}, {24'd0, es});
    chk({nm, " cout"}, {31'd0, cout8}, {31'd0, ec});
    @(posedge clk); #1;
    chk({nm, " done_one_cycle"}, {31'd0, done8}, 32'd0);
    chk({nm, " sum_hold"}, {24'd0, sum8}, {24'd0, es});
  endtask

  initial begin
    int d1, d2, k, dcnt, lat, exp5;

    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;

    vecs[0]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[1]  = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
    vecs[2]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[4]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[5]  = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
    vecs[6]  = '{8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1};
    vecs[7]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[8]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[9]  = '{8'h64, 8'hC8, 1'b1, 8'h2D, 1'b1};
    vecs[10] = '{8'hFE, 8'hFF, 1'b1, 8'hFE, 1'b1};

    // Reset state
    #2;
    chk("reset busy", {31'd0, busy8}, 32'd0);
    chk("reset done", {31'd0, done8}, 32'd0);
    chk("reset sum",  {24'd0, sum8}, 32'd0);
    chk("reset cout", {31'd0, cout8}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven operations
    for (int i = 0; i < 11; i++) begin
      do_op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, $sformatf("vec%0d", i));
    end

    // Start during RUN is ignored; previous result is held meanwhile
    do_op8(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, "prev");
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    a8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("ign busy_mid", {31'd0, busy8}, 32'd1);
    chk("ign sum_hold_mid", {24'd0, sum8}, 32'h00);
    lat = 3;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ign latency", lat, 8);
    chk("ign sum", {24'd0, sum8}, 32'h46);
    chk("ign cout", {31'd0, cout8}, 32'd0);

    // Asynchronous reset mid-RUN aborts without done
    @(posedge clk); #1;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("rst pre sum_hold", {24'd0, sum8}, 32'h46);
    rst_n = 1'b0;
    #1;
    chk("rst async busy", {31'd0, busy8}, 32'd0);
    chk("rst async done", {31'd0, done8}, 32'd0);
    chk("rst async sum",  {24'd0, sum8}, 32'd0);
    chk("rst async cout", {31'd0, cout8}, 32'd0);
    dcnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done8) dcnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 || busy8) dcnt++;
    end
    chk("rst no_done", dcnt, 0);
    chk("rst sum_after", {24'd0, sum8}, 32'd0);

    // First start accepted on the first edge with rst_n released
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; a8 = 8'h03; b8 = 8'h04; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("first busy", {31'd0, busy8}, 32'd1);
    lat = 0;
    while (!done8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("first latency", lat, 8);
    chk("first sum", {24'd0, sum8}, 32'h08);

    // Back-to-back with start held through DONE
    @(posedge clk); #1;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h7F; b8 = 8'h01;
    d1 = -1; d2 = -1; k = 0;
    while (d2 < 0 && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (done8) begin
        if (d1 < 0) begin
          d1 = k;
          chk("b2b sum1", {24'd0, sum8}, 32'h02);
        end else begin
          d2 = k;
          chk("b2b sum2", {24'd0, sum8}, 32'h80);
          chk("b2b cout2", {31'd0, cout8}, 32'd0);
        end
      end
      if (k == 9) start8 = 1'b0;
    end
    chk("b2b first_done", d1, 8);
    chk("b2b spacing", d2 - d1, 9);
    @(posedge clk); #1;

    // Exhaustive WIDTH=4 sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          @(negedge clk);
          a4 = ia[3:0]; b4 = ib[3:0]; cin4 = ic[0]; start4 = 1'b1;
          @(posedge clk); #1;
          start4 = 1'b0;
          a4 = ~a4;
          lat = 0;
          while (!done4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
          end
          exp5 = ia + ib + ic;
          chk($sformatf("w4 %0h+%0h+%0d", ia, ib, ic), {27'd0, cout4, sum4}, exp5);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_serial_adder
